// File: rtl/alu_result_display.sv
// ALU result reader: synchronises and stability-filters {O,S,C2,F}, then shows
// the captured value on a 4-digit multiplexed common-anode seven-segment display.
module alu_result_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] F,
  input  logic       C2,
  input  logic [2:0] S,
  input  logic [1:0] O,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       upd
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef struct packed {
    logic [1:0] o;
    logic [2:0] s;
    logic       c2;
    logic [7:0] f;
  } cap_t;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  cap_t          s1, s2, cap;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    idx, idx_nx;
  state_t        state, state_nx;
  logic [3:0]    an_nx;
  logic [6:0]    seg_nx;
  logic          dp_nx;
  logic [3:0]    nib;
  logic          load;

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'b1000000;
      4'h1: font = 7'b1111001;
      4'h2: font = 7'b0100100;
      4'h3: font = 7'b0110000;
      4'h4: font = 7'b0011001;
      4'h5: font = 7'b0010010;
      4'h6: font = 7'b0000010;
      4'h7: font = 7'b1111000;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0010000;
      4'ha: font = 7'b0001000;
      4'hb: font = 7'b0000011;
      4'hc: font = 7'b1000110;
      4'hd: font = 7'b0100001;
      4'he: font = 7'b0000110;
      default: font = 7'b0001110;
    endcase
  endfunction

  // A value is only taken once two consecutive samples agree.
  assign load = (s2 == s1) && !hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= '0;
      s2  <= '0;
      cap <= '0;
      upd <= 1'b0;
    end else begin
      s1  <= cap_t'({O, S, C2, F});
      s2  <= s1;
      upd <= load && (s2 != cap);
      if (load) cap <= s2;
    end
  end

  assign tick = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= tick ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BLANK;
      idx   <= 2'd0;
      an    <= 4'b1111;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      an    <= an_nx;
      seg   <= seg_nx;
      dp    <= dp_nx;
    end
  end

  // Outputs are registered from the next state/index and the current cap.
  always_comb begin
    state_nx = state;
    idx_nx   = tick ? idx + 2'd1 : idx;
    an_nx    = 4'b1111;
    seg_nx   = 7'b1111111;
    dp_nx    = 1'b1;
    nib      = 4'h0;
    case (state)
      BLANK:   state_nx = DRIVE;
      DRIVE:   if (tick) state_nx = BLANK;
      default: state_nx = BLANK;
    endcase
    case (idx_nx)
      2'd0:    nib = cap.f[3:0];
      2'd1:    nib = cap.f[7:4];
      2'd2:    nib = {3'b000, cap.c2};
      default: nib = {1'b0, cap.s};
    endcase
    if (state_nx == DRIVE) begin
      an_nx  = ~(4'b0001 << idx_nx);
      seg_nx = font(nib);
      dp_nx  = !((idx_nx == 2'd3) && (cap.o == 2'b11));
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display: expected digits are queued when the
// inputs are driven and popped as the display scans each frame.
module tb_alu_result_display;
  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] F;
  logic       C2;
  logic [2:0] S;
  logic [1:0] O;
  logic       hold;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       upd;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .F(F), .C2(C2), .S(S), .O(O), .hold(hold),
    .an(an), .seg(seg), .dp(dp), .upd(upd)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexfont(input logic [3:0] v);
    case (v)
      4'h0: hexfont = 7'b1000000;  4'h1: hexfont = 7'b1111001;
      4'h2: hexfont = 7'b0100100;  4'h3: hexfont = 7'b0110000;
      4'h4: hexfont = 7'b0011001;  4'h5: hexfont = 7'b0010010;
      4'h6: hexfont = 7'b0000010;  4'h7: hexfont = 7'b1111000;
      4'h8: hexfont = 7'b0000000;  4'h9: hexfont = 7'b0010000;
      4'ha: hexfont = 7'b0001000;  4'hb: hexfont = 7'b0000011;
      4'hc: hexfont = 7'b1000110;  4'hd: hexfont = 7'b0100001;
      4'he: hexfont = 7'b0000110;  default: hexfont = 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [7:0] f, input logic c2, input logic [2:0] s,
                            input logic [1:0] o);
    sb.push_back({hexfont(f[3:0]), 1'b1});
    sb.push_back({hexfont(f[7:4]), 1'b1});
    sb.push_back({hexfont({3'b000, c2}), 1'b1});
    sb.push_back({hexfont({1'b0, s}), !(o == 2'b11)});
  endtask

  // Waits for the start of digit 0, then checks one full frame against the queue.
  task automatic observe_frame();
    exp_t       e;
    logic [3:0] prev, want;
    int         n;
    bit         found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = an;
      step();
      if (prev == 4'b1111 && an == 4'b1110) found = 1'b1;
    end
    chk("frame_start", 32'(found), 32'd1);
    for (int d = 0; d < 4; d++) begin
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      if (found) begin
        want = 4'(~(4'b0001 << d));
        n = 0;
        while (an == want && n < 8) begin
          chk("seg", 32'(seg), 32'(e.seg));
          chk("dp", 32'(dp), 32'(e.dp));
          chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
          n++;
          step();
        end
        chk("drive_len", n, SCAN_DIV - 1);
        chk("blank_an", 32'(an), 32'hf);
        chk("blank_seg", 32'(seg), 32'h7f);
        chk("blank_dp", 32'(dp), 32'd1);
        step();
      end
    end
  endtask

  initial begin
    int   pulses;
    bit   hit;
    rst = 1'b0; F = 8'h00; C2 = 1'b0; S = 3'd0; O = 2'd0; hold = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_upd", 32'(upd), 32'd0);
    rst = 1'b1;
    step();
    chk("rel_an", 32'(an), 32'he);
    chk("rel_seg", 32'(seg), 32'h40);

    // Capture latency: upd only after the third edge
    F = 8'ha5; C2 = 1'b1; S = 3'b011; O = 2'b00;
    step(); chk("upd_e1", 32'(upd), 32'd0);
    step(); chk("upd_e2", 32'(upd), 32'd0);
    step(); chk("upd_e3", 32'(upd), 32'd1);
    step(); chk("upd_e4", 32'(upd), 32'd0);
    push_frame(8'ha5, 1'b1, 3'b011, 2'b00);
    observe_frame();

    // Hold freezes capture
    hold = 1'b1; F = 8'h3c;
    for (int i = 0; i < 6; i++) begin step(); chk("hold_upd", 32'(upd), 32'd0); end
    push_frame(8'ha5, 1'b1, 3'b011, 2'b00);
    observe_frame();
    hold = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin step(); pulses += int'(upd); end
    chk("release_pulses", pulses, 1);
    push_frame(8'h3c, 1'b1, 3'b011, 2'b00);
    observe_frame();

    // Glitching input never captured
    for (int i = 0; i < 20; i++) begin
      F[0] = ~F[0];
      step();
      chk("glitch_upd", 32'(upd), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin step(); chk("settle_upd", 32'(upd), 32'd0); end
    push_frame(8'h3c, 1'b1, 3'b011, 2'b00);
    observe_frame();

    // Decimal point on digit 3 when O == 11
    O = 2'b11;
    repeat (4) step();
    push_frame(8'h3c, 1'b1, 3'b011, 2'b11);
    observe_frame();

    // Asynchronous reset while digit 2 is driven
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      if (an == 4'b1011) hit = 1'b1;
      else step();
    end
    chk("found_digit2", 32'(hit), 32'd1);
    #2;
    rst = 1'b0; F = 8'h00; C2 = 1'b0; S = 3'd0; O = 2'd0;
    #1;
    chk("async_an", 32'(an), 32'hf);
    chk("async_seg", 32'(seg), 32'h7f);
    chk("async_dp", 32'(dp), 32'd1);
    chk("async_upd", 32'(upd), 32'd0);
    @(negedge clk);
    step();
    rst = 1'b1;
    step();
    chk("rerel_an", 32'(an), 32'he);
    chk("rerel_seg", 32'(seg), 32'h40);
    push_frame(8'h00, 1'b0, 3'd0, 2'd0);
    observe_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
